// File: rtl/mem_indirect_sequencer.sv
// mem_indirect_sequencer: MEM-stage memory access sequencer for the lc3b pipeline.
// Runs direct loads/stores and indirect (pointer-chasing) loads/stores against a
// single-port memory with a mem_resp handshake. It holds the pipeline via proceed
// until the final data access has completed.
// Optional build macro MEM_SEQ_TIMEOUT_EN: aborts an access that waits longer than
// TIMEOUT_CYC cycles and reports it on err. Without it, err is tied low and
// accesses wait indefinitely.
module mem_indirect_sequencer #(
    parameter int DATA_W      = 16,
    parameter int IND_DEPTH   = 1,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_store,
    input  logic              req_ind,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              mem_resp,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              proceed,
    output logic [DATA_W-1:0] rdata_out,
    output logic              err
);

    localparam int               LVL_W    = $clog2(IND_DEPTH + 1);
    localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(IND_DEPTH - 1);

    if (IND_DEPTH < 1 || IND_DEPTH > 7 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("mem_indirect_sequencer: IND_DEPTH must be 1..7 and TIMEOUT_CYC >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PTR   = 2'd1,
        S_FINAL = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ptr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [LVL_W-1:0]  lvl_q;
    logic              store_q;
    logic              timeout_hit;

`ifdef MEM_SEQ_TIMEOUT_EN
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYC - 1);

    logic [WAIT_W-1:0] wait_q;
    logic              err_q;
    logic              busy;

    assign busy        = (state_q == S_PTR) || (state_q == S_FINAL);
    assign timeout_hit = busy && !mem_resp && (wait_q == WAIT_LAST);
    assign err         = err_q;

    // Count unanswered cycles of the current access; restart on response or state change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
        end else if (busy && !mem_resp && !timeout_hit) begin
            wait_q <= wait_q + WAIT_W'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // Abort flag: raised by a timeout, accompanies proceed in DONE, dropped when leaving DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if (state_q == S_DONE) begin
            err_q <= 1'b0;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; strobes depend only on state so they stay up until mem_resp.
    always_comb begin
        state_d   = state_q;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        proceed   = 1'b0;
        case (state_q)
            S_IDLE: begin
                proceed = !req_valid;
                if (req_valid) begin
                    state_d = req_ind ? S_PTR : S_FINAL;
                end
            end
            S_PTR: begin
                mem_read = 1'b1;
                if (mem_resp) begin
                    state_d = (lvl_q == LVL_LAST) ? S_FINAL : S_PTR;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_FINAL: begin
                mem_read  = !store_q;
                mem_write = store_q;
                if (mem_resp || timeout_hit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                proceed = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operation context: request latched in IDLE, pointer chased in PTR, load data captured in FINAL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            lvl_q   <= '0;
            store_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        ptr_q   <= req_addr;
                        wdata_q <= req_wdata;
                        store_q <= req_store;
                        lvl_q   <= '0;
                    end
                end
                S_PTR: begin
                    if (mem_resp) begin
                        ptr_q <= {mem_rdata[DATA_W-1:1], 1'b0};
                        lvl_q <= lvl_q + LVL_W'(1);
                    end
                end
                S_FINAL: begin
                    if (mem_resp && !store_q) begin
                        rdata_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = ptr_q;
    assign mem_wdata = wdata_q;
    assign rdata_out = rdata_q;

endmodule

// File: tb/tb_mem_indirect_sequencer.sv
// Testbench for mem_indirect_sequencer: random and directed memory ops against a
// sparse memory responder, compared with a pointer-chase reference model.
module tb_mem_indirect_sequencer;

    localparam int DEPTH = 3;
    localparam int TO    = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_store, req_ind;
    logic [15:0] req_addr, req_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_read, mem_write;
    logic [15:0] mem_addr, mem_wdata;
    logic        proceed;
    logic [15:0] rdata_out;
    logic        err;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] mem [logic [15:0]];
    logic [15:0] hold_rdata = 16'h0000;

    mem_indirect_sequencer #(
        .DATA_W     (16),
        .IND_DEPTH  (DEPTH),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_store(req_store),
        .req_ind  (req_ind),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .mem_resp (mem_resp),
        .mem_rdata(mem_rdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .proceed  (proceed),
        .rdata_out(rdata_out),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Memory contents; untouched locations get a random value on first read.
    function automatic logic [15:0] rd(input logic [15:0] a);
        if (!mem.exists(a)) mem[a] = 16'($urandom);
        return mem[a];
    endfunction

    // One complete op: the model lists the expected accesses, the loop plays memory.
    task automatic run_op(input logic st, input logic ind, input logic [15:0] addr,
                          input logic [15:0] wd, input int lat);
        logic [15:0] ea[$];
        logic        ew[$];
        logic [15:0] p;
        logic [15:0] exp_rd;
        int          exp_cyc, cyc, acc_idx, wcnt, k;
        bit          done;

        p = addr;
        if (ind) begin
            for (int i = 0; i < DEPTH; i++) begin
                ea.push_back(p);
                ew.push_back(1'b0);
                p = rd(p) & 16'hFFFE;
            end
        end
        ea.push_back(p);
        ew.push_back(st);
        exp_rd  = st ? hold_rdata : rd(p);
        exp_cyc = 1 + ea.size() * (lat + 1);

        @(negedge clk);
        check_val("idle_proceed", {31'd0, proceed}, {31'd0, !req_valid});
        req_valid = 1'b1; req_store = st; req_ind = ind;
        req_addr  = addr; req_wdata = wd; mem_resp = 1'b0;
        #1;
        check_val("accept_proceed", {31'd0, proceed}, 32'd0);
        @(posedge clk);
        cyc = 0; acc_idx = 0; wcnt = 0; done = 0;
        while (!done && cyc < 100) begin
            @(negedge clk);
            cyc++;
            req_addr  = 16'($urandom); req_wdata = 16'($urandom);
            req_store = 1'($urandom);  req_ind   = 1'($urandom);
            mem_resp  = 1'b0;          mem_rdata = 16'($urandom);
            if (proceed) begin
                check_val("done_cycle", cyc, exp_cyc);
                check_val("access_count", acc_idx, ea.size());
                check_val("rdata_out", {16'd0, rdata_out}, {16'd0, exp_rd});
                check_val("err_done", {31'd0, err}, 32'd0);
                check_val("strobe_in_done", {30'd0, mem_read, mem_write}, 32'd0);
                if (!st) hold_rdata = exp_rd;
                req_valid = 1'b0;
                mem_resp  = 1'($urandom);
                done      = 1;
            end else if (mem_read || mem_write) begin
                k = (acc_idx < ea.size()) ? acc_idx : ea.size() - 1;
                if (acc_idx >= ea.size()) check_val("extra_access", acc_idx, ea.size() - 1);
                check_val(wcnt == 0 ? "access_addr" : "addr_stable", {16'd0, mem_addr}, {16'd0, ea[k]});
                check_val("access_kind", {30'd0, mem_read, mem_write}, ew[k] ? 32'd1 : 32'd2);
                if (ew[k] && wcnt == 0) check_val("write_data", {16'd0, mem_wdata}, {16'd0, wd});
                if (wcnt == lat) begin
                    mem_resp = 1'b1;
                    if (mem_write) mem[mem_addr] = mem_wdata;
                    else           mem_rdata = rd(mem_addr);
                    acc_idx++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end else begin
                check_val("busy_without_strobe", {31'd0, mem_read | mem_write}, 32'd1);
            end
        end
        if (!done) check_val("op_cycle_budget", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int  n;
        bit  done;

        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_ind = 1'b0;
        req_addr = '0; req_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;
        #3;
        check_val("rst_read", {31'd0, mem_read}, 32'd0);
        check_val("rst_write", {31'd0, mem_write}, 32'd0);
        check_val("rst_proceed", {31'd0, proceed}, 32'd1);
        check_val("rst_rdata", {16'd0, rdata_out}, 32'd0);
        check_val("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // Directed: direct load, indirect load chain, depth-3 indirect store with slow memory.
        mem[16'h3000] = 16'hBEEF;
        run_op(1'b0, 1'b0, 16'h3000, 16'h0000, 0);
        check_val("direct_load_val", {16'd0, rdata_out}, 32'h0000BEEF);
        mem[16'h3000] = 16'h4001; mem[16'h4000] = 16'h5003;
        mem[16'h5002] = 16'h6000; mem[16'h6000] = 16'h1234;
        run_op(1'b0, 1'b1, 16'h3000, 16'h0000, 0);
        check_val("ind_load_val", {16'd0, rdata_out}, 32'h00001234);
        run_op(1'b1, 1'b1, 16'h3000, 16'h00AA, 3);
        check_val("ind_store_mem", {16'd0, mem[16'h6000]}, 32'h000000AA);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom), 1'($urandom), 16'($urandom), 16'($urandom), int'($urandom_range(3, 0)));
        end

        // Stray responses while idle are ignored.
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_resp = 1'b1; mem_rdata = 16'($urandom);
            @(negedge clk);
            check_val("stray_proceed", {31'd0, proceed}, 32'd1);
            check_val("stray_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        end
        mem_resp = 1'b0;

        // Guarantee rdata_out is non-zero before the mid-op reset.
        mem[16'h2000] = 16'h5A5A;
        run_op(1'b0, 1'b0, 16'h2000, 16'h0000, 1);

        // Asynchronous reset while a pointer read is outstanding.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_ind = 1'b1; req_addr = 16'h3000;
        @(negedge clk);
        check_val("pre_reset_read", {31'd0, mem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("midrst_read", {31'd0, mem_read}, 32'd0);
        check_val("midrst_proceed", {31'd0, proceed}, 32'd0);
        check_val("midrst_rdata", {16'd0, rdata_out}, 32'd0);
        req_valid = 1'b0;
        #1;
        check_val("midrst_idle_proceed", {31'd0, proceed}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_val("midrst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        end
        rst_n = 1'b1;
        hold_rdata = 16'h0000;
        run_op(1'b1, 1'b0, 16'h1000, 16'hC3C3, 0);
        check_val("post_rst_store_mem", {16'd0, mem[16'h1000]}, 32'h0000C3C3);
        run_op(1'b0, 1'b1, 16'h3000, 16'h0000, 2);

`ifdef MEM_SEQ_TIMEOUT_EN
        // No response at all: access is abandoned after TO strobe cycles.
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b0; req_ind = 1'b0; req_addr = 16'h3000; mem_resp = 1'b0;
        @(posedge clk);
        n = 0; done = 0;
        for (int c = 0; c < 4 * TO && !done; c++) begin
            @(negedge clk);
            if (proceed) begin
                check_val("timeout_strobe_cycles", n, TO);
                check_val("timeout_err", {31'd0, err}, 32'd1);
                req_valid = 1'b0;
                done = 1;
            end else if (mem_read) begin
                n++;
            end
        end
        if (!done) check_val("timeout_budget", {31'd0, done}, 32'd1);
        @(negedge clk);
        check_val("timeout_err_clear", {31'd0, err}, 32'd0);
`else
        n = 0; done = 0;
        if (n != 0 || done) $display("unused");
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
